// File: rtl/aes_round_sequencer.sv
// Iterative AES round controller: one block in flight, NUM_ROUNDS rounds per block.
// Define AES_SEQ_TIMEOUT_EN to enable the sticky per-round WAIT watchdog (timeout_err).
`timescale 1ns/1ps
module aes_round_sequencer #(
  parameter int NUM_ROUNDS    = 10,
  parameter int ROUND_LATENCY = 1,
  parameter int ROUND_TIMEOUT = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       key_ready,
  output logic       dp_load,
  output logic       dp_round_start,
  output logic       dp_final_round,
  input  logic       dp_round_done,
  output logic [3:0] round_key_idx,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       busy,
  output logic       timeout_err
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS);

  generate
    if (NUM_ROUNDS != 10 && NUM_ROUNDS != 12 && NUM_ROUNDS != 14) begin : g_bad_rounds
      $fatal(1, "aes_round_sequencer: NUM_ROUNDS must be 10, 12 or 14");
    end
    if (ROUND_LATENCY < 1) begin : g_bad_latency
      $fatal(1, "aes_round_sequencer: ROUND_LATENCY must be >= 1");
    end
    if (ROUND_TIMEOUT < 1) begin : g_bad_timeout
      $fatal(1, "aes_round_sequencer: ROUND_TIMEOUT must be >= 1");
    end
  endgenerate

  logic [1:0] r_state;
  logic [1:0] w_state_nxt;
  logic [3:0] r_round_cnt;
  logic [3:0] w_round_cnt_nxt;
  logic       r_armed;
  logic       w_accept;
  logic       w_last_round;
  logic       w_timeout;

  // r_armed keeps in_ready low until the first clock edge after reset releases.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_armed <= 1'b0;
    end else begin
      r_armed <= 1'b1;
    end
  end

  assign w_last_round   = (r_round_cnt == LAST_ROUND);
  assign in_ready       = r_armed & (r_state == S_IDLE) & key_ready;
  assign w_accept       = in_valid & in_ready;
  assign dp_load        = w_accept;
  assign dp_round_start = (r_state == S_ISSUE);
  assign dp_final_round = (r_state == S_ISSUE) & w_last_round;
  assign round_key_idx  = ((r_state == S_ISSUE) || (r_state == S_WAIT)) ? r_round_cnt : 4'd0;
  assign out_valid      = (r_state == S_DONE);
  assign busy           = (r_state != S_IDLE);

`ifdef AES_SEQ_TIMEOUT_EN
  localparam int TMO_W = $clog2(ROUND_TIMEOUT + 1);

  logic [TMO_W-1:0] r_wait_cnt;
  logic             r_timeout_err;

  assign w_timeout = (r_state == S_WAIT) & ~dp_round_done &
                     (r_wait_cnt == TMO_W'(ROUND_TIMEOUT - 1));

  // Counter sits at zero outside WAIT so it restarts on every WAIT entry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wait_cnt    <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      if (r_state != S_WAIT) begin
        r_wait_cnt <= '0;
      end else begin
        r_wait_cnt <= r_wait_cnt + TMO_W'(1);
      end
      if (w_timeout) begin
        r_timeout_err <= 1'b1;
      end
    end
  end

  assign timeout_err = r_timeout_err;
`else
  assign w_timeout   = 1'b0;
  assign timeout_err = 1'b0;
`endif

  // dp_round_done only matters in WAIT; ISSUE ignores a same-cycle done.
  always_comb begin
    w_state_nxt     = r_state;
    w_round_cnt_nxt = r_round_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_nxt     = S_ISSUE;
          w_round_cnt_nxt = 4'd1;
        end
      end
      S_ISSUE: begin
        w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (dp_round_done) begin
          if (w_last_round) begin
            w_state_nxt = S_DONE;
          end else begin
            w_state_nxt     = S_ISSUE;
            w_round_cnt_nxt = r_round_cnt + 4'd1;
          end
        end else if (w_timeout) begin
          w_state_nxt     = S_IDLE;
          w_round_cnt_nxt = 4'd0;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          w_state_nxt     = S_IDLE;
          w_round_cnt_nxt = 4'd0;
        end
      end
      default: begin
        w_state_nxt     = S_IDLE;
        w_round_cnt_nxt = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_round_cnt <= 4'd0;
    end else begin
      r_state     <= w_state_nxt;
      r_round_cnt <= w_round_cnt_nxt;
    end
  end

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Scoreboard bench for aes_round_sequencer: transaction-level expectations vs. a passive monitor.
`timescale 1ns/1ps
module tb_aes_round_sequencer;

  localparam int NR      = 10;
  localparam int K_LOAD  = 0;
  localparam int K_START = 1;
  localparam int K_OUT   = 2;

  typedef struct {
    int kind;
    int cyc;
    int idx;
    int fin;
    int hold;
  } ev_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       in_valid = 1'b0;
  logic       key_ready = 1'b0;
  logic       dp_round_done = 1'b0;
  logic       out_ready = 1'b0;
  logic       in_ready, dp_load, dp_round_start, dp_final_round, out_valid, busy, timeout_err;
  logic [3:0] round_key_idx;

  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  ev_t  exp_q[$];
  ev_t  e;
  int   ov_end = 0;
  bit   ov_track = 0;
  int   m_last_idx = 0;
  bit   mon_idx_en = 1;
  int   dp_lat = 1;
  int   hang_idx = 0;
  int   cd = 0;
  bit   dp_busy = 0;
  bit   spur_en = 0;
  logic d_nxt;

  aes_round_sequencer #(
    .NUM_ROUNDS   (NR),
    .ROUND_LATENCY(1),
    .ROUND_TIMEOUT(8)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .key_ready     (key_ready),
    .dp_load       (dp_load),
    .dp_round_start(dp_round_start),
    .dp_final_round(dp_final_round),
    .dp_round_done (dp_round_done),
    .round_key_idx (round_key_idx),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .busy          (busy),
    .timeout_err   (timeout_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic void push_ev(input int kind, input int c, input int idx, input int fin, input int hold);
    ev_t x;
    x.kind = kind; x.cyc = c; x.idx = idx; x.fin = fin; x.hold = hold;
    exp_q.push_back(x);
  endfunction

  // Reference: accept at T, each round is one issue cycle plus L datapath cycles.
  function automatic void push_block(input int T, input int L, input int H);
    push_ev(K_LOAD, T, 0, 0, 0);
    for (int k = 1; k <= NR; k++)
      push_ev(K_START, T + 1 + (k - 1) * (L + 1), k, (k == NR) ? 1 : 0, 0);
    push_ev(K_OUT, T + 1 + NR * (L + 1), 0, 0, H);
  endfunction

  // Datapath model: done L cycles after a start; optional stray done pulses when not busy.
  initial forever begin
    @(negedge clk);
    d_nxt = 1'b0;
    if (reset) begin
      cd = 0;
      dp_busy = 0;
    end else begin
      if (cd > 0) begin
        cd = cd - 1;
        if (cd == 0) begin
          d_nxt = 1'b1;
          dp_busy = 0;
        end
      end
      if (dp_round_start) begin
        dp_busy = 1;
        if (spur_en) d_nxt = 1'($urandom_range(1));
        if (int'(round_key_idx) != hang_idx) cd = dp_lat;
      end else if (!dp_busy && spur_en && $urandom_range(3) == 0) begin
        d_nxt = 1'b1;
      end
    end
    dp_round_done = d_nxt;
  end

  // Monitor: pops expectations whenever the DUT presents an event.
  initial forever begin
    @(negedge clk);
    if (reset) begin
      exp_q.delete();
      ov_track = 0;
      m_last_idx = 0;
    end else begin
      if (dp_load) begin
        if (exp_q.size() > 0 && exp_q[0].kind == K_LOAD) begin
          e = exp_q.pop_front();
          chk("load_cycle", cyc, e.cyc);
        end else chk("load_unexpected", dp_load, 0);
      end
      if (dp_round_start) begin
        if (exp_q.size() > 0 && exp_q[0].kind == K_START) begin
          e = exp_q.pop_front();
          chk("start_cycle", cyc, e.cyc);
          chk("start_idx", round_key_idx, e.idx);
          chk("final_round", dp_final_round, e.fin);
          m_last_idx = e.idx;
        end else chk("start_unexpected", dp_round_start, 0);
      end else begin
        chk("final_round_idle", dp_final_round, 0);
        if (mon_idx_en) chk("key_idx_hold", round_key_idx, out_valid ? 0 : m_last_idx);
      end
      if (ov_track) begin
        if (cyc <= ov_end) begin
          chk("out_valid_held", out_valid, 1);
          chk("busy_in_done", busy, 1);
        end else begin
          chk("out_valid_drop", out_valid, 0);
          ov_track = 0;
        end
      end else if (out_valid) begin
        if (exp_q.size() > 0 && exp_q[0].kind == K_OUT) begin
          e = exp_q.pop_front();
          chk("out_cycle", cyc, e.cyc);
          ov_end = cyc + e.hold;
          ov_track = 1;
          m_last_idx = 0;
        end else chk("out_unexpected", out_valid, 0);
      end
    end
  end

  task automatic do_reset();
    reset = 1; in_valid = 1; key_ready = 1; out_ready = 1;
    #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_dp_load", dp_load, 0);
    chk("rst_start", dp_round_start, 0);
    chk("rst_final", dp_final_round, 0);
    chk("rst_key_idx", round_key_idx, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_timeout_err", timeout_err, 0);
    tick();
    tick();
    reset = 0; in_valid = 0; out_ready = 0;
    #1;
    chk("in_ready_before_first_edge", in_ready, 0);
    tick();
    #1;
    chk("in_ready_after_first_edge", in_ready, 1);
    chk("idle_busy", busy, 0);
  endtask

  task automatic send_block(input int L, input int H, input int kr_off, input bit early, input int abort_at);
    int T, R;
    dp_lat = L;
    in_valid = 1;
    for (int i = 0; i < kr_off; i++) begin
      key_ready = 0;
      #1;
      chk("in_ready_no_key", in_ready, 0);
      chk("dp_load_no_key", dp_load, 0);
      tick();
      in_valid = 1;
    end
    key_ready = 1;
    T = cyc;
    R = T + 1 + NR * (L + 1);
    push_block(T, L, H);
    out_ready = (H == 0);
    #1;
    chk("in_ready_accept", in_ready, 1);
    while (1) begin
      tick();
      if (abort_at != 0 && cyc == T + abort_at) begin
        do_reset();
        return;
      end
      if (cyc > R + H) break;
      if (early && cyc >= R) begin
        in_valid = 1; key_ready = 1; out_ready = (cyc == R + H);
        #1;
        chk("in_ready_while_done", in_ready, 0);
        chk("busy_while_done", busy, 1);
      end else begin
        in_valid = 1'($urandom_range(1));
        key_ready = 1'($urandom_range(1));
        if (cyc < R) out_ready = (H == 0) ? 1'b1 : 1'($urandom_range(1));
        else out_ready = (cyc == R + H);
      end
    end
    in_valid = early; key_ready = 1; out_ready = 0;
  endtask

  task automatic hang_block();
    int T;
    dp_lat = 1; hang_idx = 2; mon_idx_en = 0;
    in_valid = 1; key_ready = 1; out_ready = 0;
    T = cyc;
    push_ev(K_LOAD, T, 0, 0, 0);
    push_ev(K_START, T + 1, 1, 0, 0);
    push_ev(K_START, T + 3, 2, 0, 0);
    tick();
    in_valid = 0;
`ifdef AES_SEQ_TIMEOUT_EN
    while (cyc < T + 11) tick();
    #1;
    chk("tmo_not_yet", timeout_err, 0);
    chk("tmo_busy_before", busy, 1);
    tick();
    #1;
    chk("tmo_flag", timeout_err, 1);
    chk("tmo_idle", busy, 0);
    chk("tmo_in_ready", in_ready, 1);
    chk("tmo_key_idx", round_key_idx, 0);
`else
    while (cyc < T + 20) tick();
    #1;
    chk("hang_busy", busy, 1);
    chk("hang_no_tmo", timeout_err, 0);
`endif
    tick();
    do_reset();
    hang_idx = 0;
    mon_idx_en = 1;
  endtask

  initial begin
    bit prev_early;
    bit early;
    reset = 1;
    tick();
    tick();
    do_reset();
    // Nominal block, fixed one-cycle datapath, no stray done pulses.
    spur_en = 0;
    tick();
    send_block(1, 0, 0, 0, 0);
    repeat (2) tick();
    spur_en = 1;
    // Key schedule not ready for five cycles.
    send_block(1, 0, 5, 0, 0);
    tick();
    // Downstream stalls in DONE; next block waits for the cycle after the handshake.
    send_block(2, 6, 0, 1, 0);
    send_block(1, 0, 0, 0, 0);
    tick();
    // Reset during WAIT of round 4.
    send_block(1, 0, 0, 0, 8);
    repeat (30) tick();
    send_block(1, 0, 0, 0, 0);
    prev_early = 0;
    for (int i = 0; i < 6; i++) begin
      if (!prev_early) tick();
      early = 1'($urandom_range(1));
      send_block($urandom_range(1, 4), $urandom_range(0, 4), $urandom_range(0, 2), early, 0);
      prev_early = early;
    end
    if (!prev_early) tick();
    send_block(3, 2, 0, 0, 0);
    tick();
    hang_block();
    repeat (5) tick();
    chk("queue_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
